// File: rtl/vec_pack.sv
// Vector packer: gathers signed BW-bit elements into VECTOR_LEN-wide packed vectors,
// flushing early (zero-padded) on last_i, with valid/last/ready handshakes on both sides.
module vec_pack #(
    parameter int BW         = 18,
    parameter int VECTOR_LEN = 2,
    parameter int CNT_W      = $clog2(VECTOR_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BW-1:0]            data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic [VECTOR_LEN*BW-1:0] data_o,
    output logic [CNT_W-1:0]         cnt_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    // A single-element vector still needs a 1-bit index register.
    localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(VECTOR_LEN - 1);

    logic [IDX_W-1:0]         idx_r;
    logic [VECTOR_LEN*BW-1:0] stage_r;
    logic [VECTOR_LEN*BW-1:0] vec_s;
    logic                     in_fire_s;
    logic                     out_fire_s;
    logic                     complete_s;

    assign ready_o    = !rst_i && (!valid_o || ready_i);
    assign in_fire_s  = valid_i && ready_o;
    assign out_fire_s = valid_o && ready_i;
    assign complete_s = in_fire_s && ((idx_r == IDX_MAX) || last_i);

    // Assemble the outgoing vector: staged slots below idx, current element at idx, zeros above.
    always_comb begin
        vec_s = '0;
        for (int k = 0; k < VECTOR_LEN; k++) begin
            if (k < int'(idx_r)) begin
                vec_s[k*BW +: BW] = stage_r[k*BW +: BW];
            end else if (k == int'(idx_r)) begin
                vec_s[k*BW +: BW] = data_i;
            end else begin
                vec_s[k*BW +: BW] = '0;
            end
        end
    end

    // Index counter and staging register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_r   <= '0;
            stage_r <= '0;
        end else if (complete_s) begin
            idx_r   <= '0;
            stage_r <= '0;
        end else if (in_fire_s) begin
            idx_r                          <= idx_r + IDX_W'(1);
            stage_r[int'(idx_r)*BW +: BW] <= data_i;
        end else begin
            idx_r   <= idx_r;
            stage_r <= stage_r;
        end
    end

    // Output register: a completing beat reloads it even while the previous vector drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            cnt_o   <= '0;
            last_o  <= 1'b0;
            valid_o <= 1'b0;
        end else if (complete_s) begin
            data_o  <= vec_s;
            cnt_o   <= CNT_W'(idx_r) + CNT_W'(1);
            last_o  <= last_i;
            valid_o <= 1'b1;
        end else if (out_fire_s) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_o;
        end
    end

    vec_pack_chk #(
        .BW         (BW),
        .VECTOR_LEN (VECTOR_LEN),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_o  (data_o),
        .cnt_o   (cnt_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

endmodule

// Protocol checks on the output side of vec_pack.
module vec_pack_chk #(
    parameter int BW         = 18,
    parameter int VECTOR_LEN = 2,
    parameter int CNT_W      = $clog2(VECTOR_LEN + 1)
) (
    input logic                     clk_i,
    input logic                     rst_i,
    input logic [VECTOR_LEN*BW-1:0] data_o,
    input logic [CNT_W-1:0]         cnt_o,
    input logic                     valid_o,
    input logic                     last_o,
    input logic                     ready_i
);

    // A stalled vector must stay put until the consumer takes it.
    hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(cnt_o) && $stable(last_o)));

    cnt_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_o |-> ((cnt_o >= CNT_W'(1)) && (cnt_o <= CNT_W'(VECTOR_LEN))));

endmodule

// File: doc/vec_pack.md
# vec_pack

Vector packer: collects a stream of signed BW-bit scalar elements into a packed VECTOR_LEN-element vector. It emits one vector per VECTOR_LEN accepted elements, or earlier, zero-padded, when a stream ends on `last_i`. It sits upstream of the reduction adder in the wake-word datapath and produces the packed-vector stream that the adder consumes, using the same valid/last/ready handshake.

## Interface
- `BW`, 18: element bitwidth (signed two's complement).
- `VECTOR_LEN`, 2: elements per output vector; legal range is VECTOR_LEN >= 1.
- `CNT_W`, $clog2(VECTOR_LEN+1): width of the element-count output.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  BW  input element.
- `valid_i`  in  1  input element valid.
- `last_i`  in  1  marks the final element of a stream; qualified by `valid_i`.
- `ready_o`  out  1  block can accept an element this cycle.
- `data_o`  out  VECTOR_LEN*BW  packed vector; element k occupies bits [(k+1)*BW-1 : k*BW].
- `cnt_o`  out  CNT_W  number of valid elements in `data_o`, in the range 1..VECTOR_LEN.
- `valid_o`  out  1  output vector valid.
- `last_o`  out  1  output vector contains the stream's final element.
- `ready_i`  in  1  downstream accepts the vector.

## Operation
- **Input handshake:** accept when `valid_i && ready_o`. Output handshake: transfer when `valid_o && ready_i`.
- **`ready_o`:** combinational, `ready_o = !rst_i && (!valid_o || ready_i)`.
- **Index counter and staging:**
  - Index counter `idx_q` runs 0..VECTOR_LEN-1.
  - An accepted element is written into staging slot `idx_q`, so the first-received element lands at slot 0.
- **Completion:** an accepted beat completes a vector when `idx_q == VECTOR_LEN-1` or `last_i == 1`. On completion:
  - the output register loads the staging contents together with the current element;
  - slots above `idx_q` are loaded as zero;
  - `cnt_o <= idx_q+1`, `last_o <= last_i`, `valid_o <= 1`;
  - `idx_q` returns to 0 and the staging register clears to zero.
- **Non-completing beat:** `idx_q` increments; outputs are unchanged.
- **Output hold:** while `valid_o && !ready_i`, `data_o`, `cnt_o` and `last_o` hold stable and `ready_o` is 0, so no input is accepted.
- **Output drain:** on an output transfer with no completing input beat in the same cycle, `valid_o <= 0`. `data_o`, `cnt_o` and `last_o` may keep their last values.
- **Simultaneous drain and completion:** the output register loads the new vector and `valid_o` stays 1. There is no bubble.
- **`last_i` on the final slot** (`idx_q == VECTOR_LEN-1`): produces exactly one vector with `cnt_o = VECTOR_LEN` and `last_o = 1`. No trailing empty vector is emitted.
- **VECTOR_LEN = 1:** every accepted beat completes a vector with `cnt_o = 1`.
- **No arithmetic:** elements are copied bit-exact. No sign extension or saturation is applied.

## Timing
- **Reset:** `rst_i` asserted forces, immediately (asynchronously):
  - `valid_o = 0`, `last_o = 0`, `cnt_o = 0`, `data_o = 0`;
  - `idx_q = 0` and staging cleared;
  - `ready_o = 0` while `rst_i` is high.
- **After reset release:** `ready_o = 1` from the first cycle after release.
- **Reset mid-vector:** discards the partial vector and any pending output vector without emitting either.
- **Latency:** a completing beat accepted at edge N gives `valid_o = 1` with the new vector after edge N. That is one cycle, registered.
- **Throughput:** with `valid_i` and `ready_i` held at 1, one vector every VECTOR_LEN cycles.
- **Protocol assumption:** upstream must hold `data_i`, `valid_i` and `last_i` stable until accepted. The block does not check this.
- **No combinational path** from any input to `valid_o`, `data_o`, `cnt_o` or `last_o`.

## Test plan
- **Basic pack (VECTOR_LEN=2, BW=18, `ready_i`=1):** send 5 then -3 → one cycle after the second accept:
  - `data_o[17:0] = 0x00005`, `data_o[35:18] = 0x3FFFD`;
  - `cnt_o = 2`, `last_o = 0`;
  - `valid_o` high for exactly 1 cycle.
- **Partial flush (VECTOR_LEN=4):** send 1, 2, 3 with `last_i` on 3 → slots {0:1, 1:2, 2:3, 3:0}, `cnt_o = 3`, `last_o = 1`. Then send 7 four times → `cnt_o = 4`, 7 in every slot, `last_o = 0`.
- **Backpressure (VECTOR_LEN=2):** hold `ready_i = 0` for 5 cycles after a vector appears → `ready_o = 0`, outputs stable throughout. On release:
  - no element is lost or duplicated;
  - 8 sequential elements arrive as vectors {0,1}, {2,3}, {4,5}, {6,7}.
- **Streaming (VECTOR_LEN=4):** continuous `valid_i` and `ready_i` for 16 beats → `valid_o` pulses every 4th cycle, 4 vectors in order, and `ready_o` never drops.
- **Last on boundary (VECTOR_LEN=2):** send a, then b with `last_i` → exactly one vector with `cnt_o = 2` and `last_o = 1`; `valid_o` stays 0 afterwards.
- **Async reset mid-vector (VECTOR_LEN=4):** after 2 accepted beats, assert `rst_i` between clock edges:
  - all outputs go to 0 before the next edge;
  - after release, 4 new beats form one clean vector with `cnt_o = 4`.
